mem_port_arbiter: RTL and testbench

Sequences and shares the single 8-bit memory port between the instruction-fetch requester (driven by the control unit's fetch_enable / instruction_ready handshake) and the data load/store requester. Only one transaction is in flight at a time. Data requests win arbitration by default, and a starvation counter guarantees fetch progress. A per-transaction watchdog converts a missing memory acknowledge into an error response so the control unit never hangs in WAIT_FETCH.

---
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and the shared memory port seen by mem_port_arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;
    logic              bus_err;
    logic              grant_d;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_ready, if_rdata, d_ready, d_rdata, bus_err, grant_d,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_ready, if_rdata, d_ready, d_rdata, bus_err, grant_d,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 8-bit memory port between instruction fetch and data load/store,
// one transaction at a time, with data priority, fetch anti-starvation and an ack watchdog.
module mem_port_arbiter #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT        = 15,
    parameter int DATA_BURST_MAX = 3
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int WD_W = 8;
    localparam int BC_W = $clog2(DATA_BURST_MAX + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [BC_W-1:0] BC_MAX  = BC_W'(DATA_BURST_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [BC_W-1:0]   burst_q, burst_d;
    logic              grant_q, grant_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ready_q, if_ready_d;
    logic              d_ready_q, d_ready_d;
    logic              bus_err_q, bus_err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              any_req_s;
    logic              pick_d_s;
    logic              ack_s;
    logic              timeout_s;
    logic [DATA_W-1:0] rsp_data_s;

    // Arbitration and completion qualifiers; ack only counts while the strobe is up.
    always_comb begin
        any_req_s  = bus.if_req | bus.d_req;
        ack_s      = mem_en_q & bus.mem_ack;
        timeout_s  = (state_q == ST_BUSY) & ~ack_s & (wd_q == WD_LAST);
        rsp_data_s = ack_s ? bus.mem_rdata : {DATA_W{1'b0}};
        pick_d_s   = 1'b0;
        if (bus.d_req && !bus.if_req) begin
            pick_d_s = 1'b1;
        end else if (bus.d_req && bus.if_req) begin
            pick_d_s = (burst_q != BC_MAX);
        end else begin
            pick_d_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) state_d = ST_BUSY;
                else           state_d = ST_IDLE;
            end
            ST_BUSY: begin
                if (ack_s || timeout_s) state_d = ST_RESP;
                else                    state_d = ST_BUSY;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; ready and error are single-cycle pulses into RESP.
    always_comb begin
        wd_d        = wd_q;
        burst_d     = burst_q;
        grant_d     = grant_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        bus_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    grant_d  = pick_d_s;
                    mem_en_d = 1'b1;
                    wd_d     = {WD_W{1'b0}};
                    if (pick_d_s) begin
                        mem_addr_d  = bus.d_addr;
                        mem_we_d    = bus.d_we;
                        mem_wdata_d = bus.d_wdata;
                    end else begin
                        mem_addr_d  = bus.if_addr;
                        mem_we_d    = 1'b0;
                    end
                    // Only a data grant that leaves a fetch waiting extends the streak.
                    if (pick_d_s && bus.if_req) begin
                        if (burst_q != BC_MAX) burst_d = burst_q + BC_W'(1);
                        else                   burst_d = burst_q;
                    end else begin
                        burst_d = {BC_W{1'b0}};
                    end
                end else begin
                    mem_en_d = 1'b0;
                end
            end
            ST_BUSY: begin
                if (ack_s || timeout_s) begin
                    mem_en_d  = 1'b0;
                    mem_we_d  = 1'b0;
                    bus_err_d = timeout_s;
                    if (grant_q) begin
                        d_ready_d = 1'b1;
                        if (!mem_we_q) d_rdata_d = rsp_data_s;
                        else           d_rdata_d = d_rdata_q;
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = rsp_data_s;
                    end
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_RESP: begin
                mem_en_d = 1'b0;
            end
            default: begin
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q        <= {WD_W{1'b0}};
            burst_q     <= {BC_W{1'b0}};
            grant_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            if_rdata_q  <= {DATA_W{1'b0}};
            d_rdata_q   <= {DATA_W{1'b0}};
        end else begin
            wd_q        <= wd_d;
            burst_q     <= burst_d;
            grant_q     <= grant_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            bus_err_q   <= bus_err_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus.if_ready  = if_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.bus_err   = bus_err_q;
    assign bus.grant_d   = grant_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: random requesters, a behavioural memory with
// per-transaction ack delay (including timeouts), random resets, and a transaction-timeline model.
module tb_mem_port_arbiter;
    localparam int T    = 15;
    localparam int BMAX = 3;
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus_if ();

    mem_port_arbiter #(
        .ADDR_W(8), .DATA_W(8), .TIMEOUT(T), .DATA_BURST_MAX(BMAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // model: one transaction timeline at a time, measured in observation cycles
    bit        active;
    int        t_start, t_en_last, t_ready;
    bit        t_err, t_own, t_we;
    logic [7:0] t_addr, t_wdata, t_val;
    int        free_from;
    int        burst;
    logic [7:0] e_if_rdata, e_d_rdata, e_addr, e_wdata;
    bit        e_grant;
    logic [7:0] mem [256];
    int        delays [7] = '{1, 2, 3, 4, 15, 16, 40};

    // requester state and the values driven for the coming edge
    bit        f_pend, f_infl, d_pend, d_infl;
    logic [7:0] f_addr, d_addr_v, d_wdata_v;
    bit        d_we_v;
    bit        rq_f, rq_d, rq_dwe;
    logic [7:0] rq_faddr, rq_daddr, rq_dwdata;
    bit        rst_prev;
    int        rst_hold;
    int        p_req;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_chk++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp_v, cyc);
        end
    endtask

    task model_step;
        int a;
        bit own;
        if (rst_prev) begin
            active     = 1'b0;
            burst      = 0;
            e_grant    = 1'b0;
            e_addr     = 8'h00;
            e_wdata    = 8'h00;
            e_if_rdata = 8'h00;
            e_d_rdata  = 8'h00;
        end else if (!active && cyc >= free_from && (rq_f || rq_d)) begin
            own     = rq_d && (!rq_f || burst < BMAX);
            burst   = (own && rq_f) ? burst + 1 : 0;
            t_own   = own;
            t_addr  = own ? rq_daddr : rq_faddr;
            t_we    = own && rq_dwe;
            if (own) e_wdata = rq_dwdata;
            t_wdata = e_wdata;
            e_addr  = t_addr;
            e_grant = own;
            a         = delays[$urandom_range(0, 6)];
            t_start   = cyc;
            t_err     = (a > T);
            t_en_last = cyc + (t_err ? T : a) - 1;
            t_ready   = t_en_last + 1;
            active    = 1'b1;
            if (own) begin d_pend = 1'b0; d_infl = 1'b1; end
            else     begin f_pend = 1'b0; f_infl = 1'b1; end
        end
        if (active && cyc == t_ready) begin
            if (!t_own)     e_if_rdata = t_err ? 8'h00 : t_val;
            else if (!t_we) e_d_rdata  = t_err ? 8'h00 : t_val;
        end
        chk("mem_en",    32'(bus_if.mem_en),    32'(active && cyc <= t_en_last));
        chk("mem_we",    32'(bus_if.mem_we),    32'(active && cyc <= t_en_last && t_we));
        chk("mem_addr",  32'(bus_if.mem_addr),  32'(e_addr));
        chk("mem_wdata", 32'(bus_if.mem_wdata), 32'(e_wdata));
        chk("grant_d",   32'(bus_if.grant_d),   32'(e_grant));
        chk("if_ready",  32'(bus_if.if_ready),  32'(active && cyc == t_ready && !t_own));
        chk("d_ready",   32'(bus_if.d_ready),   32'(active && cyc == t_ready && t_own));
        chk("bus_err",   32'(bus_if.bus_err),   32'(active && cyc == t_ready && t_err));
        chk("if_rdata",  32'(bus_if.if_rdata),  32'(e_if_rdata));
        chk("d_rdata",   32'(bus_if.d_rdata),   32'(e_d_rdata));
        if (active && cyc == t_ready) begin
            active    = 1'b0;
            free_from = cyc + 2;
            if (t_own) d_infl = 1'b0;
            else       f_infl = 1'b0;
        end
    endtask

    task drive_step;
        if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) begin
                rst       = 1'b0;
                free_from = cyc + 1;
            end
        end else if (cyc > 20 && $urandom_range(0, 299) == 0) begin
            rst      = 1'b1;
            rst_hold = 2;
            f_pend   = 1'b0;
            f_infl   = 1'b0;
            d_pend   = 1'b0;
            d_infl   = 1'b0;
        end

        // memory: ack after the chosen number of strobe cycles, noise on ack while idle
        if (active && cyc == t_en_last && !t_err) begin
            if (t_we) mem[t_addr] = t_wdata;
            t_val            = mem[t_addr];
            bus_if.mem_ack   = 1'b1;
            bus_if.mem_rdata = t_val;
        end else if (active && cyc <= t_en_last) begin
            bus_if.mem_ack   = 1'b0;
            bus_if.mem_rdata = 8'($urandom);
        end else begin
            bus_if.mem_ack   = ($urandom_range(0, 3) == 0);
            bus_if.mem_rdata = 8'($urandom);
        end

        p_req = (cyc < 1000) ? 90 : ((cyc < 2000) ? 30 : 70);
        if (!rst) begin
            if (!f_pend && !f_infl && $urandom_range(0, 99) < p_req) begin
                f_pend = 1'b1;
                f_addr = 8'($urandom_range(0, 31));
            end
            if (!d_pend && !d_infl && $urandom_range(0, 99) < p_req) begin
                d_pend    = 1'b1;
                d_we_v    = 1'($urandom_range(0, 1));
                d_addr_v  = 8'($urandom_range(0, 15));
                d_wdata_v = 8'($urandom);
            end
        end
        // after grant the requester may wiggle req and bus fields freely
        bus_if.if_req  = f_infl ? 1'($urandom_range(0, 1)) : f_pend;
        bus_if.if_addr = f_infl ? 8'($urandom) : f_addr;
        bus_if.d_req   = d_infl ? 1'($urandom_range(0, 1)) : d_pend;
        bus_if.d_we    = d_infl ? 1'($urandom_range(0, 1)) : d_we_v;
        bus_if.d_addr  = d_infl ? 8'($urandom) : d_addr_v;
        bus_if.d_wdata = d_infl ? 8'($urandom) : d_wdata_v;

        rq_f      = bus_if.if_req;
        rq_faddr  = bus_if.if_addr;
        rq_d      = bus_if.d_req;
        rq_dwe    = bus_if.d_we;
        rq_daddr  = bus_if.d_addr;
        rq_dwdata = bus_if.d_wdata;
        rst_prev  = rst;
    endtask

    initial begin
        rst              = 1'b1;
        rst_prev         = 1'b1;
        rst_hold         = 3;
        free_from        = 0;
        active           = 1'b0;
        t_val            = 8'h00;
        f_pend           = 1'b0;
        f_infl           = 1'b0;
        d_pend           = 1'b0;
        d_infl           = 1'b0;
        f_addr           = 8'h00;
        d_we_v           = 1'b0;
        d_addr_v         = 8'h00;
        d_wdata_v        = 8'h00;
        bus_if.if_req    = 1'b0;
        bus_if.if_addr   = 8'h00;
        bus_if.d_req     = 1'b0;
        bus_if.d_we      = 1'b0;
        bus_if.d_addr    = 8'h00;
        bus_if.d_wdata   = 8'h00;
        bus_if.mem_ack   = 1'b0;
        bus_if.mem_rdata = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        repeat (NCYC) begin
            @(negedge clk);
            cyc++;
            model_step();
            drive_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
